// File: rtl/xs_sdr_pkg.sv
// Shared types and helpers for the SDRAM ROM read arbiter.
package xs_sdr_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/xs_arb_picker.sv
// Combinational grant picker: fixed lowest-index or round-robin from rr_ptr.
module xs_arb_picker
  import xs_sdr_pkg::*;
#(
  parameter int NCH  = 5,
  parameter int MODE = ARB_RR,
  parameter int PW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] elig,
  input  logic [PW-1:0]  rr_ptr,
  output logic           gnt_vld,
  output logic [PW-1:0]  gnt
);
  logic [7:0] oh;

  // Scan in priority order; the first eligible channel found wins.
  always_comb begin
    int idx;
    oh  = '0;
    idx = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (MODE == ARB_FIXED) ? k : (int'(rr_ptr) + k) % NCH;
      if (elig[PW'(idx)] && oh == '0) oh[3'(idx)] = 1'b1;
    end
  end

  assign gnt_vld = |oh;
  assign gnt     = PW'(onehot2idx(oh));
endmodule

// File: rtl/xs_sdr_rom_arbiter.sv
// N-channel ROM read arbiter onto one SDRAM read port, with a per-channel
// last-word cache and a hold input that freezes new grants.
module xs_sdr_rom_arbiter
  import xs_sdr_pkg::*;
#(
  parameter int NCH      = 5,
  parameter int AW       = 25,
  parameter int DW       = 16,
  parameter int MODE     = 1,
  parameter int CACHE_EN = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH-1:0]    ch_req,
  output logic [NCH-1:0]    ch_rdy,
  output logic [DW-1:0]     ch_dout,
  input  logic [NCH-1:0]    ch_inv,
  input  logic              hold,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_req,
  input  logic              mem_rdy,
  input  logic [DW-1:0]     mem_dout,
  output logic              busy
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t                  state, state_nx;
  logic [NCH-1:0][AW-1:0]  addr_v, c_addr;
  logic [NCH-1:0][DW-1:0]  c_data;
  logic [NCH-1:0]          guard, elig, valid;
  logic [PW-1:0]           rr_ptr, gnt, cur;
  logic [AW-1:0]           gnt_addr;
  logic                    gnt_vld, hit, do_hit, do_issue, do_fill;

  assign addr_v   = ch_addr;
  assign elig     = ch_req & ~guard & ~{NCH{hold}};
  assign gnt_addr = addr_v[gnt];
  assign hit      = (CACHE_EN != 0) && valid[gnt] && (c_addr[gnt] == gnt_addr);

  xs_arb_picker #(.NCH(NCH), .MODE(MODE), .PW(PW)) u_pick (
    .elig    (elig),
    .rr_ptr  (rr_ptr),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_vld && !hit) state_nx = WAIT;
      WAIT:    if (mem_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    do_hit   = 1'b0;
    do_issue = 1'b0;
    do_fill  = 1'b0;
    case (state)
      IDLE: begin
        do_hit   = gnt_vld && hit;
        do_issue = gnt_vld && !hit;
      end
      WAIT:    do_fill = mem_rdy;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ch_rdy   <= '0;
      ch_dout  <= '0;
      mem_addr <= '0;
      mem_req  <= 1'b0;
      rr_ptr   <= '0;
      valid    <= '0;
      guard    <= '0;
      cur      <= '0;
    end else begin
      guard  <= ch_rdy;
      ch_rdy <= '0;
      valid  <= valid & ~ch_inv;
      if (state == IDLE && gnt_vld)
        rr_ptr <= (gnt == PW'(NCH-1)) ? '0 : gnt + PW'(1);
      if (do_hit) begin
        ch_rdy[gnt] <= 1'b1;
        ch_dout     <= c_data[gnt];
      end
      if (do_issue) begin
        cur      <= gnt;
        mem_addr <= gnt_addr;
        mem_req  <= 1'b1;
      end
      // A coincident invalidate keeps the entry empty but still returns data.
      if (do_fill) begin
        mem_req     <= 1'b0;
        ch_dout     <= mem_dout;
        ch_rdy[cur] <= 1'b1;
        valid[cur]  <= ~ch_inv[cur];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (do_fill) begin
      c_addr[cur] <= mem_addr;
      c_data[cur] <= mem_dout;
    end
  end
endmodule
